// File: rtl/traffic_phase_seq_if.sv
// Bundle between the phase sequencer and its Timer/display side.
// Optional pedestrian signals exist only when PED_REQUEST_EN is defined.
// master: the Timer/environment side. slave: the sequencer.
interface traffic_phase_seq_if #(
  parameter int W = 7
);
  logic         trigger;
  logic [W-1:0] time_remaining;
  logic [W-1:0] timer_ref;
  logic [2:0]   lights;
  logic [1:0]   phase;
  logic [3:0]   disp_tens;
  logic [3:0]   disp_ones;
  logic         disp_ovf;
`ifdef PED_REQUEST_EN
  logic         ped_req;
  logic         ped_walk;

  modport master (
    output trigger, time_remaining, ped_req,
    input  timer_ref, lights, phase, disp_tens, disp_ones, disp_ovf, ped_walk
  );
  modport slave (
    input  trigger, time_remaining, ped_req,
    output timer_ref, lights, phase, disp_tens, disp_ones, disp_ovf, ped_walk
  );
`else
  modport master (
    output trigger, time_remaining,
    input  timer_ref, lights, phase, disp_tens, disp_ones, disp_ovf
  );
  modport slave (
    input  trigger, time_remaining,
    output timer_ref, lights, phase, disp_tens, disp_ones, disp_ovf
  );
`endif
endinterface

// File: rtl/traffic_phase_seq.sv
// Traffic-light phase sequencer: steps RED -> GREEN -> YELLOW -> ALLRED on
// each Timer trigger pulse, feeds the next phase duration back to the Timer,
// and converts time_remaining into two registered BCD display digits.
// Optional feature macro: PED_REQUEST_EN (pedestrian request / walk lamp).
module traffic_phase_seq #(
  parameter int W           = 7,
  parameter int RED_TIME    = 30,
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2,
  parameter int PED_GREEN   = 10
) (
  input logic clock,
  input logic reset,
  traffic_phase_seq_if.slave bus
);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_ALLRED = 2'd3
  } phase_t;

  // Phase durations truncated to the Timer width.
  localparam logic [W-1:0] RED_T    = W'(RED_TIME);
  localparam logic [W-1:0] GREEN_T  = W'(GREEN_TIME);
  localparam logic [W-1:0] YELLOW_T = W'(YELLOW_TIME);
  localparam logic [W-1:0] ALLRED_T = W'(ALLRED_TIME);

  phase_t       state_reg;
  logic [W-1:0] timer_ref_reg;
  logic [2:0]   lights_reg;
  logic [3:0]   tens_reg, ones_reg;
  logic         ovf_reg;
  logic [3:0]   tens_next, ones_next;
  logic         ovf_next;
  int           value_int;
  logic [9:1]   at_least;

`ifdef PED_REQUEST_EN
  localparam logic [W-1:0] PED_G = W'(PED_GREEN);
  logic ped_pending_reg;
  logic ped_served_reg;
  logic ped_walk_reg;
`else
  logic unused_ped_green;
  assign unused_ped_green = ^W'(PED_GREEN);
`endif

  // Phase FSM: advance one phase per trigger pulse, all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= PH_RED;
      timer_ref_reg <= RED_T;
      lights_reg    <= 3'b100;
`ifdef PED_REQUEST_EN
      ped_pending_reg <= 1'b0;
      ped_served_reg  <= 1'b0;
      ped_walk_reg    <= 1'b0;
`endif
    end else begin
`ifdef PED_REQUEST_EN
      if (bus.ped_req) ped_pending_reg <= 1'b1;
`endif
      if (bus.trigger) begin
        case (state_reg)
          PH_RED: begin
            state_reg  <= PH_GREEN;
            lights_reg <= 3'b001;
`ifdef PED_REQUEST_EN
            // A pending request shortens this GREEN and earns the next RED a walk.
            timer_ref_reg  <= ped_pending_reg ? PED_G : GREEN_T;
            ped_served_reg <= ped_pending_reg;
            ped_walk_reg   <= 1'b0;
`else
            timer_ref_reg <= GREEN_T;
`endif
          end
          PH_GREEN: begin
            state_reg     <= PH_YELLOW;
            lights_reg    <= 3'b010;
            timer_ref_reg <= YELLOW_T;
          end
          PH_YELLOW: begin
            state_reg     <= PH_ALLRED;
            lights_reg    <= 3'b100;
            timer_ref_reg <= ALLRED_T;
          end
          default: begin
            state_reg     <= PH_RED;
            lights_reg    <= 3'b100;
            timer_ref_reg <= RED_T;
`ifdef PED_REQUEST_EN
            // Serve the walk; a request on this very edge stays pending.
            ped_walk_reg   <= ped_served_reg;
            ped_served_reg <= 1'b0;
            if (ped_served_reg) ped_pending_reg <= bus.ped_req;
`endif
          end
        endcase
      end
    end
  end

  // Compare ladder: at_least[k] says time_remaining >= 10*k.
  assign value_int = int'(bus.time_remaining);
  for (genvar gi = 1; gi < 10; gi++) begin : g_ladder
    assign at_least[gi] = (value_int >= gi * 10);
  end

  // Pick the highest satisfied rung; saturate above 99.
  always_comb begin
    tens_next = 4'd0;
    ones_next = 4'(value_int);
    ovf_next  = (value_int > 99);
    for (int k = 1; k < 10; k++) begin
      if (at_least[k]) begin
        tens_next = 4'(k);
        ones_next = 4'(value_int - k * 10);
      end
    end
    if (ovf_next) begin
      tens_next = 4'd9;
      ones_next = 4'd9;
    end
  end

  // Display registers: follow time_remaining every edge, independent of phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      tens_reg <= 4'd0;
      ones_reg <= 4'd0;
      ovf_reg  <= 1'b0;
    end else begin
      tens_reg <= tens_next;
      ones_reg <= ones_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign bus.timer_ref = timer_ref_reg;
  assign bus.lights    = lights_reg;
  assign bus.phase     = state_reg;
  assign bus.disp_tens = tens_reg;
  assign bus.disp_ones = ones_reg;
  assign bus.disp_ovf  = ovf_reg;
`ifdef PED_REQUEST_EN
  assign bus.ped_walk  = ped_walk_reg;
`endif

endmodule

// File: tb/tb_traffic_phase_seq.sv
// Scoreboard bench for traffic_phase_seq: stimulus pushes expected outputs,
// a negedge monitor pops and compares them once the DUT has had its edge.
module tb_traffic_phase_seq;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  traffic_phase_seq_if #(.W(7)) bus ();

  traffic_phase_seq #(
    .W(7), .RED_TIME(3), .GREEN_TIME(4), .YELLOW_TIME(1), .ALLRED_TIME(0), .PED_GREEN(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

`ifdef PED_REQUEST_EN
  initial bus.ped_req = 1'b0;
`endif

  typedef struct {
    int         tgt;
    string      tag;
    logic [1:0] ph;
    logic [2:0] li;
    logic [6:0] rf;
    logic [3:0] t;
    logic [3:0] o;
    logic       ov;
  } exp_t;

  exp_t q[$];
  exp_t e;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: compare every expectation that targets the edge just taken.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].tgt <= cyc) begin
      e = q.pop_front();
      if (e.tgt < cyc) chk({e.tag, "_late"}, cyc, e.tgt);
      chk({e.tag, "_phase"},  int'(bus.phase),     int'(e.ph));
      chk({e.tag, "_lights"}, int'(bus.lights),    int'(e.li));
      chk({e.tag, "_ref"},    int'(bus.timer_ref), int'(e.rf));
      chk({e.tag, "_tens"},   int'(bus.disp_tens), int'(e.t));
      chk({e.tag, "_ones"},   int'(bus.disp_ones), int'(e.o));
      chk({e.tag, "_ovf"},    int'(bus.disp_ovf),  int'(e.ov));
      $display("txn %s cyc=%0d phase=%0d lights=%b ref=%0d disp=%0d%0d ovf=%0d",
               e.tag, cyc, bus.phase, bus.lights, bus.timer_ref,
               bus.disp_tens, bus.disp_ones, bus.disp_ovf);
    end
  end

  // Drive one cycle of inputs and queue what must appear after the next edge.
  task automatic step(input string tag, input logic rst, input logic trig, input int tr,
                      input int ph, input int li, input int rf,
                      input int t, input int o, input int ov);
    exp_t x;
    reset              = rst;
    bus.trigger        = trig;
    bus.time_remaining = 7'(tr);
    x.tgt = cyc + 1;
    x.tag = tag;
    x.ph  = 2'(ph);
    x.li  = 3'(li);
    x.rf  = 7'(rf);
    x.t   = 4'(t);
    x.o   = 4'(o);
    x.ov  = 1'(ov);
    q.push_back(x);
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.trigger        = 1'b0;
    bus.time_remaining = 7'd0;
    @(posedge clock);
    #1;
    // Reset held with trigger toggling: stays RED, digits cleared.
    step("rst0", 1'b1, 1'b1, 50, 0, 3'b100, 3, 0, 0, 0);
    step("rst1", 1'b1, 1'b0, 77, 0, 3'b100, 3, 0, 0, 0);
    step("rst2", 1'b1, 1'b1, 120, 0, 3'b100, 3, 0, 0, 0);
    step("idle", 1'b0, 1'b0, 0, 0, 3'b100, 3, 0, 0, 0);
    // Five back-to-back triggers with the BCD vectors alongside.
    step("seq1", 1'b0, 1'b1, 9,   1, 3'b001, 4, 0, 9, 0);
    step("seq2", 1'b0, 1'b1, 57,  2, 3'b010, 1, 5, 7, 0);
    step("seq3", 1'b0, 1'b1, 99,  3, 3'b100, 0, 9, 9, 0);
    step("seq4", 1'b0, 1'b1, 100, 0, 3'b100, 3, 9, 9, 1);
    step("seq5", 1'b0, 1'b1, 127, 1, 3'b001, 4, 9, 9, 1);
    // Hold GREEN for 50 cycles with no trigger; display tracks the input.
    for (int i = 0; i < 50; i++)
      step("hold", 1'b0, 1'b0, i, 1, 3'b001, 4, i / 10, i % 10, 0);
    step("toyel", 1'b0, 1'b1, 5, 2, 3'b010, 1, 0, 5, 0);
    // Reset mid-YELLOW together with trigger: reset wins.
    step("rstmid", 1'b1, 1'b1, 33, 0, 3'b100, 3, 0, 0, 0);
    step("after0", 1'b0, 1'b0, 12, 0, 3'b100, 3, 1, 2, 0);
    step("after1", 1'b0, 1'b1, 88, 1, 3'b001, 4, 8, 8, 0);
    bus.trigger = 1'b0;
    // Bounded drain of the scoreboard.
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clock);
    #1;
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
